int_sequencer: RTL

Sequential interrupt controller for the 8051 core. It sits between the SFR block (IE, IP, TCON, SCON) and the instruction-sequencing FSM. It resolves the five interrupt sources across two priority levels and tracks nesting with in-service bits. It hands one vector at a time to the core over a req/ack handshake and issues the hardware flag-clear pulses for IE0/TF0/IE1/TF1.

---
 rtl/int_sequencer_if.sv | 26 ++
 rtl/int_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bus: SFR inputs, core handshake and controller outputs.
// Handshake: int_req is held with int_vec/int_grant stable until the core pulses int_ack for one cycle or the request is withdrawn.
interface int_sequencer_if;
  logic [7:0]  ie;
  logic [4:0]  ip;
  logic [4:0]  int_flag;
  logic [1:0]  it;
  logic        int_block;
  logic        int_ack;
  logic        reti;
  logic        int_req;
  logic [15:0] int_vec;
  logic [4:0]  int_grant;
  logic [3:0]  clr_flag;
  logic [1:0]  in_service;

  modport master (
    output ie, ip, int_flag, it, int_block, int_ack, reti,
    input  int_req, int_vec, int_grant, clr_flag, in_service
  );

  modport slave (
    input  ie, ip, int_flag, it, int_block, int_ack, reti,
    output int_req, int_vec, int_grant, clr_flag, in_service
  );
endinterface

// File: rtl/int_sequencer.sv
// 8051 interrupt sequencer: two-level priority arbitration, in-service nesting
// tracking and flag-clear pulses, one request at a time to the core.
module int_sequencer #(
  parameter logic [15:0] VEC_BASE = 16'h0003,
  parameter int          VEC_STEP = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  int_sequencer_if.slave bus,
  output logic           state_dbg_o
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  grant_q, grant_d;
  logic        lvl_q, lvl_d;
  logic [15:0] vec_q, vec_d;
  logic [3:0]  clr_q, clr_d;
  logic [1:0]  is_q, is_d;

  logic [4:0]  pend;
  logic [4:0]  elig_hi;
  logic [4:0]  elig_lo;
  logic [4:0]  cand;
  logic [4:0]  win_oh;
  logic [2:0]  win_idx;

  // Eligibility uses the registered in_service, so a reti frees a level one cycle later.
  always_comb begin
    pend    = bus.int_flag & bus.ie[4:0] & {5{bus.ie[7]}};
    elig_hi = pend & bus.ip & {5{~is_q[1]}};
    elig_lo = pend & ~bus.ip & {5{is_q == 2'b00}};
    cand    = (elig_hi != 5'b0) ? elig_hi : elig_lo;
    win_oh  = cand & (~cand + 5'd1);
    win_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (cand[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lvl_d   = lvl_q;
    vec_d   = vec_q;
    clr_d   = 4'b0;
    is_d    = is_q;

    // reti clears first so a same-cycle ack can set its level afterwards.
    if (bus.reti) begin
      if (is_q[1]) is_d[1] = 1'b0;
      else         is_d[0] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if ((cand != 5'b0) && !bus.int_block) begin
          state_d = REQ;
          grant_d = win_oh;
          lvl_d   = |(win_oh & bus.ip);
          vec_d   = VEC_BASE + 16'(VEC_STEP) * {13'd0, win_idx};
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          if (lvl_q) is_d[1] = 1'b1;
          else       is_d[0] = 1'b1;
          clr_d   = {grant_q[3], grant_q[2] & bus.it[1], grant_q[1], grant_q[0] & bus.it[0]};
          state_d = IDLE;
          grant_d = 5'b0;
          lvl_d   = 1'b0;
          vec_d   = 16'h0000;
        end else if ((grant_q & pend) == 5'b0) begin
          state_d = IDLE;
          grant_d = 5'b0;
          lvl_d   = 1'b0;
          vec_d   = 16'h0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 5'b0;
      lvl_q   <= 1'b0;
      vec_q   <= 16'h0000;
      clr_q   <= 4'b0;
      is_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lvl_q   <= lvl_d;
      vec_q   <= vec_d;
      clr_q   <= clr_d;
      is_q    <= is_d;
    end
  end

  assign bus.int_req    = (state_q == REQ);
  assign bus.int_vec    = vec_q;
  assign bus.int_grant  = grant_q;
  assign bus.clr_flag   = clr_q;
  assign bus.in_service = is_q;
  assign state_dbg_o    = state_q;

endmodule
